// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, ALUOp codes,
// and the select-field encodings also used by the extender and the datapath.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, so the extender is ready in any state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps the FSM's ALUOp and the instruction funct fields to ALUControl.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_t    ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    logic w_is_sub;

    // Only R-type (op[5]=1) uses funct7b5 to select sub; addi with a negative imm must stay add.
    assign w_is_sub = op5 & funct7b5;

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V core (lw, sw, R-type, I-type ALU, jal, beq).
// dbg_state exposes the current state for observation; it has no datapath role.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [3:0] dbg_state
);

    state_t     r_state;
    state_t     w_next_state;
    alu_op_t    w_alu_op;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_alu_op     = ALUOP_ADD;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RD2;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_ITYPE:     w_next_state = S_EXECUTEI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_RD2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_RD2;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

    // Write enables are gated by rst so a reset cycle can never commit architectural state.
    assign PCWrite   = ~rst & (w_pc_update | (w_branch & Zero));
    assign MemWrite  = ~rst & w_mem_write;
    assign IRWrite   = ~rst & w_ir_write;
    assign RegWrite  = ~rst & w_reg_write;
    assign AdrSrc    = w_adr_src;
    assign ResultSrc = w_result_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign ImmSrc    = imm_src_of(op);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: randomized instruction stream against a step-table model,
// plus directed scenarios with hand-computed expectations.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    // Model step names (bench-local numbering, independent of the RTL encoding).
    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
    localparam int T_MEMWRITE = 5, T_EXR = 6, T_EXI = 7, T_ALUWB = 8, T_JAL = 9, T_BEQ = 10;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Bit 16 flags a reset cycle (only write enables checked); bits 15:0 are the control word.
    logic [16:0] exp_q[$];

    // Per-instruction observations for the directed scenarios.
    int         n_cyc;
    logic [7:0] v_pc, v_rw, v_mw, v_irw, v_adr;
    logic [1:0] a_res[8];
    logic [1:0] a_imm[8];
    logic [2:0] a_alu[8];
    logic [3:0] a_state[8];

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] funct_ctl(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Control word {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc}.
    function automatic logic [15:0] expect_ctrl(input int s, input logic [6:0] o, input logic [2:0] f3,
                                                input logic f7, input logic z);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] res = 0, sa = 0, sb = 0;
        logic [2:0] alu = 3'b000;
        case (s)
            T_FETCH:    begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  begin adr = 1; end
            T_MEMWB:    begin res = 2'b01; rw = 1; end
            T_MEMWRITE: begin adr = 1; mw = 1; end
            T_EXR:      begin sa = 2'b10; alu = funct_ctl(o, f3, f7); end
            T_EXI:      begin sa = 2'b10; sb = 2'b01; alu = funct_ctl(o, f3, f7); end
            T_ALUWB:    begin rw = 1; end
            T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            T_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
            default:    ;
        endcase
        return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm_model(o)};
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if (e[16])
                check("rst_enables", {28'd0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
            else
                check("ctrl_word", {16'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc}, {16'd0, e[15:0]});
        end
    end

    // ---------------- driver ----------------
    // zmode: 0/1 hold Zero at that value, 2 randomize every cycle. rst_at < 0: no reset.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int rst_at, input int zmode);
        int seq[$];
        seq = {T_FETCH, T_DECODE};
        case (o)
            7'b0000011: seq = {seq, T_MEMADR, T_MEMREAD, T_MEMWB};
            7'b0100011: seq = {seq, T_MEMADR, T_MEMWRITE};
            7'b0110011: seq = {seq, T_EXR, T_ALUWB};
            7'b0010011: seq = {seq, T_EXI, T_ALUWB};
            7'b1101111: seq = {seq, T_JAL, T_ALUWB};
            7'b1100011: seq = {seq, T_BEQ};
            default:    ;
        endcase
        n_cyc = 0;
        v_pc = 0; v_rw = 0; v_mw = 0; v_irw = 0; v_adr = 0;
        for (int k = 0; k < seq.size(); k++) begin
            @(posedge clk); #1;
            if (k == 0) begin op = o; funct3 = f3; funct7b5 = f7; end
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            rst  = (k == rst_at);
            if (k == rst_at) exp_q.push_back({1'b1, 16'h0});
            else             exp_q.push_back({1'b0, expect_ctrl(seq[k], o, f3, f7, Zero)});
            @(negedge clk);
            v_pc[k] = PCWrite; v_rw[k] = RegWrite; v_mw[k] = MemWrite;
            v_irw[k] = IRWrite; v_adr[k] = AdrSrc;
            a_res[k] = ResultSrc; a_imm[k] = ImmSrc; a_alu[k] = ALUControl; a_state[k] = dbg_state;
            n_cyc++;
            if (k == rst_at) break;
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [6:0] ops[6];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        rst = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;

        // Pin the model against hand-derived control words.
        check("model_fetch", {16'd0, expect_ctrl(T_FETCH, 7'b0000011, 3'd0, 1'b0, 1'b0)},
              {16'd0, 16'b1_0_0_1_0_10_00_10_000_00});
        check("model_beq_taken", {16'd0, expect_ctrl(T_BEQ, 7'b1100011, 3'd0, 1'b0, 1'b1)},
              {16'd0, 16'b1_0_0_0_0_00_10_00_001_10});

        // rst high for two cycles, then lw.
        repeat (2) begin
            @(posedge clk); #1;
            rst = 1'b1;
            exp_q.push_back({1'b1, 16'h0});
            @(negedge clk);
        end
        run_instr(7'b0000011, 3'd2, 1'b0, -1, 2);
        check("lw_cycles", n_cyc, 5);
        check("lw_s0", a_state[0], S_FETCH);
        check("lw_s1", a_state[1], S_DECODE);
        check("lw_s2", a_state[2], S_MEMADR);
        check("lw_s3", a_state[3], S_MEMREAD);
        check("lw_s4", a_state[4], S_MEMWB);
        check("lw_regwrite_vec", v_rw, 8'b0001_0000);
        check("lw_resultsrc_c5", a_res[4], 2'b01);

        run_instr(7'b0100011, 3'd2, 1'b0, -1, 2);
        check("sw_cycles", n_cyc, 4);
        check("sw_immsrc", a_imm[3], 2'b01);
        check("sw_memwrite_vec", v_mw, 8'b0000_1000);
        check("sw_adrsrc_c4", v_adr[3], 1'b1);
        check("sw_regwrite_vec", v_rw, 8'd0);

        run_instr(7'b1100011, 3'd0, 1'b0, -1, 1);
        check("beq_taken_pcwrite", v_pc, 8'b0000_0101);
        check("beq_taken_imm", a_imm[2], 2'b10);
        run_instr(7'b1100011, 3'd0, 1'b0, -1, 0);
        check("beq_nt_pcwrite", v_pc, 8'b0000_0001);
        check("beq_nt_imm", a_imm[2], 2'b10);
        check("beq_cycles", n_cyc, 3);

        run_instr(7'b0110011, 3'd0, 1'b1, -1, 2);
        check("rtype_sub", a_alu[2], 3'b001);
        run_instr(7'b0010011, 3'd0, 1'b1, -1, 2);
        check("itype_add", a_alu[2], 3'b000);
        run_instr(7'b0110011, 3'd7, 1'b0, -1, 2);
        check("rtype_and", a_alu[2], 3'b010);

        run_instr(7'b1101111, 3'd0, 1'b0, -1, 0);
        check("jal_imm", a_imm[2], 2'b11);
        check("jal_pcwrite", v_pc[2], 1'b1);
        check("jal_wb_state", a_state[3], S_ALUWB);
        check("jal_wb_regwrite", v_rw[3], 1'b1);

        run_instr(7'b1111111, 3'd0, 1'b0, -1, 2);
        check("illegal_cycles", n_cyc, 2);
        check("illegal_decode_we", {v_pc[1], v_mw[1], v_irw[1], v_rw[1]}, 4'b0000);

        // Reset during MEMREAD of a lw, then a fresh instruction.
        run_instr(7'b0000011, 3'd2, 1'b0, 3, 2);
        check("midrst_state_c4", a_state[3], S_MEMREAD);
        check("midrst_mw_rw", {v_mw, v_rw}, 16'd0);
        run_instr(7'b0110011, 3'd6, 1'b0, -1, 2);
        check("after_rst_fetch", a_state[0], S_FETCH);
        check("after_rst_cycles", n_cyc, 4);

        // Randomized instruction stream with occasional mid-instruction resets.
        for (int i = 0; i < 400; i++) begin
            int ra;
            if ($urandom_range(0, 7) == 0) o = 7'($urandom);
            else o = ops[$urandom_range(0, 5)];
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), ra, 2);
        end

        @(posedge clk); #1;
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 The block SHALL have port op, input, 7, opcode (instr[6:0]) from the instruction register.
REQ-005 The block SHALL have port funct3, input, 3, instr[14:12].
REQ-006 The block SHALL have port funct7b5, input, 1, instr[30].
REQ-007 The block SHALL have port Zero, input, 1, ALU zero flag.
REQ-008 The block SHALL have port PCWrite, output, 1, PC register enable.
REQ-009 The block SHALL have port AdrSrc, output, 1, memory address select: 0 = PC, 1 = ALUOut.
REQ-010 The block SHALL have ports MemWrite, IRWrite and RegWrite, output, 1 each, write enables.
REQ-011 The block SHALL have port ResultSrc, output, 2, result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 The block SHALL have port ALUSrcA, output, 2, ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-013 The block SHALL have port ALUSrcB, output, 2, ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-014 The block SHALL have port ALUControl, output, 3, ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 The block SHALL have port ImmSrc, output, 2, extender format: 00 = I, 01 = S, 10 = B, 11 = J.

Function
REQ-016 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
REQ-017 FETCH SHALL assert: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1. It SHALL always go to DECODE.
REQ-018 DECODE SHALL assert ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target), and SHALL go to:
- MEMADR for op 0000011 or 0100011
- EXECUTER for 0110011
- EXECUTEI for 0010011
- JAL for 1101111
- BEQ for 1100011
- FETCH for any other opcode (illegal; no write enable asserted).
REQ-019 MEMADR SHALL assert ALUSrcA=10, ALUSrcB=01, ALUOp=add, and SHALL go to MEMREAD for lw, MEMWRITE for sw.
REQ-020 MEMREAD SHALL assert ResultSrc=00, AdrSrc=1, then go to MEMWB. MEMWB SHALL assert ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-021 MEMWRITE SHALL assert ResultSrc=00, AdrSrc=1, MemWrite=1, then go to FETCH.
REQ-022 EXECUTER (ALUSrcA=10, ALUSrcB=00) and EXECUTEI (ALUSrcA=10, ALUSrcB=01) SHALL use ALUOp=funct and SHALL go to ALUWB.
REQ-023 ALUWB SHALL assert ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-024 JAL SHALL assert ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1, then go to ALUWB.
REQ-025 BEQ SHALL assert ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1, then go to FETCH.
REQ-026 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), evaluated combinationally in the same cycle.
REQ-027 ImmSrc SHALL be decoded combinationally from op, independent of state:
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- otherwise -> 00
REQ-028 With ALUOp=funct, ALUControl SHALL decode as follows:
- funct3 000: sub if op[5] AND funct7b5, else add
- funct3 010: slt
- funct3 110: or
- funct3 111: and
- any other funct3: add
REQ-029 Unasserted enables SHALL be 0 and unasserted select fields SHALL be 00 in every state.
REQ-030 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-031 When rst is sampled high, the state SHALL become FETCH at that edge.
REQ-032 While rst is high, PCWrite, MemWrite, IRWrite and RegWrite SHALL be forced to 0.
REQ-033 Reset asserted mid-instruction SHALL abandon the instruction with no further write enables issued.

Structure
REQ-034 The state encoding, the ALUOp codes and the ImmSrc/ResultSrc/ALUSrc encodings SHALL reside in a shared package, also used by the extender and datapath.
REQ-035 ALU decoding SHALL be a sub-module named alu_decoder, with inputs ALUOp, funct3, op5 and funct7b5, and output ALUControl.

Verification
REQ-036 Scenario: rst high for 2 cycles, then low with op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in the 5th cycle with ResultSrc=01.
REQ-037 Scenario: op=0100011 -> ImmSrc=01 and MemWrite=1 in the 4th cycle with AdrSrc=1; RegWrite stays 0 throughout.
REQ-038 Scenario: op=1100011 with Zero=1 in the BEQ cycle -> PCWrite=1 in the 3rd cycle; with Zero=0 -> PCWrite=0 in the 3rd cycle; ImmSrc=10 in both cases.
REQ-039 Scenario: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; same stimulus with op=0010011 -> ALUControl=000.
REQ-040 Scenario: op=1101111 -> ImmSrc=11, PCWrite=1 in the JAL cycle, then ALUWB with RegWrite=1.
REQ-041 Scenario: op=1111111 -> DECODE goes to FETCH with no write enables; rst asserted during MEMREAD -> FETCH on the next cycle and MemWrite/RegWrite remain 0.
